iccm_arbiter: RTL
=================

// Module: iccm_arbiter
//
// PURPOSE
//  Shares the single-port instruction memory between the core fetch port (read-only) and a
//  host/loader port (read/write). Sequences boot: host owns memory exclusively, core held
//  in halt until the program is loaded. In RUN, fetch wins by default; host has a
//  starvation bound. Sits between the core/loader and the memory wrapper (1-cycle read latency).
//
// PARAMETERS
//  ADDR_WIDTH  12  word-address width of memory and both ports
//  DATA_WIDTH  32  data width; wmask is DATA_WIDTH/8 bits
//  MAX_WAIT    4   max consecutive cycles a host request waits in RUN before forced grant (>=1)
//
// PORTS
//  clk_i         in   1    clock, all logic on posedge
//  rst_i         in   1    synchronous, active-high reset
//  boot_done_i   in   1    pulse: loader finished, BOOT -> RUN
//  reboot_i      in   1    pulse: return to BOOT (via DRAIN)
//  core_halt_o   out  1    core must not fetch; high in BOOT and DRAIN
//  core_req_i    in   1    fetch request, held until core_gnt_o
//  core_addr_i   in   AW   fetch address
//  core_gnt_o    out  1    fetch accepted this cycle (combinational)
//  core_rdata_o  out  DW   fetch data
//  core_rvalid_o out  1    fetch data valid, 1 cycle after core_gnt_o
//  host_req_i    in   1    host request, held with payload until host_gnt_o
//  host_we_i     in   1    1 = write, 0 = read
//  host_addr_i   in   AW   host address
//  host_wdata_i  in   DW   host write data
//  host_wmask_i  in   DW/8 host byte-write mask
//  host_gnt_o    out  1    host request accepted this cycle (combinational)
//  host_rdata_o  out  DW   host read data
//  host_rvalid_o out  1    host read data valid, 1 cycle after a read grant; never for writes
//  mem_req_o     out  1    memory request
//  mem_we_o      out  1    memory write enable
//  mem_addr_o    out  AW   memory address
//  mem_wdata_o   out  DW   memory write data
//  mem_wmask_o   out  DW/8 memory byte mask
//  mem_rdata_i   in   DW   memory read data
//  mem_rvalid_i  in   1    memory read valid (1 cycle after read req, 0 after write)
//
// BEHAVIOUR
//  - FSM states BOOT, RUN, DRAIN. Reset -> BOOT, wait_cnt=0, resp_pend=0.
//  - BOOT: only host granted (host_gnt_o=host_req_i); core_gnt_o=0. boot_done_i -> RUN next cycle.
//  - RUN: core_req_i granted unless host_req_i && wait_cnt==MAX_WAIT, then host granted;
//    host granted when core_req_i=0. reboot_i -> DRAIN (reboot_i wins over boot_done_i).
//  - DRAIN: no grants. Exit to BOOT once resp_pend=0 (1 cycle if none pending).
//  - At most one grant per cycle; mem_req_o = core_gnt_o | host_gnt_o; mem_* mux from winner;
//    core grant drives mem_we_o=0, mem_wmask_o=0, mem_wdata_o=0.
//  - wait_cnt (RUN only): +1 when host_req_i && !host_gnt_o, saturates at MAX_WAIT; cleared on
//    host grant, on host_req_i=0, and on leaving RUN.
//  - Response tracking: on granted READ, resp_pend<=1, resp_sel<=winner; else resp_pend<=0.
//    core_rvalid_o = mem_rvalid_i & resp_pend & resp_sel==CORE; host likewise.
//    rdata outputs = mem_rdata_i (valid only with own rvalid). Back-to-back grants allowed.
//  - Writes: complete at grant; no rvalid. mem_rvalid_i without resp_pend is ignored.
//  - Reset outputs: core_halt_o=1, all gnt/rvalid/mem_req_o/mem_we_o=0, data/addr/mask outputs 0.
//  - Reset mid-transaction: pending response dropped (no rvalid to either port next cycle).
//
// TESTING
//  1 reset, host writes 0xDEADBEEF @0x004 mask 0xF, reads back -> host_gnt_o same cycle,
//    host_rvalid_o next cycle with 0xDEADBEEF; core_req_i=1 throughout -> core_gnt_o=0, halt=1
//  2 boot_done_i -> next cycle core_halt_o=0; core reads 0x004 -> core_rvalid_o, 0xDEADBEEF
//  3 RUN, core_req_i held 1, host read pending -> host granted on exactly 5th cycle (MAX_WAIT=4),
//    core denied that cycle, wait_cnt back to 0
//  4 reboot_i same cycle as core read grant -> DRAIN, core_rvalid_o delivered, then BOOT; no grants
//    in DRAIN; core_halt_o=1 from DRAIN onward
//  5 rst_i asserted cycle after host read grant -> host_rvalid_o stays 0; state BOOT
//  6 alternating core/host reads back-to-back -> each rvalid routed to correct port, none lost

Source files
------------

// File: rtl/iccm_arbiter.sv
// iccm_arbiter: shares the single-port ICCM between core fetch and host loader, sequencing boot
module iccm_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    boot_done_i,
  input  logic                    reboot_i,
  output logic                    core_halt_o,
  input  logic                    core_req_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  output logic                    core_gnt_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_rvalid_o,
  input  logic                    host_req_i,
  input  logic                    host_we_i,
  input  logic [ADDR_WIDTH-1:0]   host_addr_i,
  input  logic [DATA_WIDTH-1:0]   host_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] host_wmask_i,
  output logic                    host_gnt_o,
  output logic [DATA_WIDTH-1:0]   host_rdata_o,
  output logic                    host_rvalid_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t state, next_state;
  logic [WW-1:0] wait_cnt;
  logic resp_pend, resp_sel, starve;
  always_comb begin
    starve        = host_req_i && wait_cnt == WW'(MAX_WAIT);
    core_gnt_o    = !rst_i && state == RUN && core_req_i && !starve;
    host_gnt_o    = !rst_i && host_req_i && (state == BOOT || (state == RUN && (!core_req_i || starve)));
    mem_req_o     = core_gnt_o || host_gnt_o;
    mem_we_o      = host_gnt_o && host_we_i;
    mem_addr_o    = host_gnt_o ? host_addr_i : core_gnt_o ? core_addr_i : '0;
    mem_wdata_o   = host_gnt_o ? host_wdata_i : '0;
    mem_wmask_o   = host_gnt_o ? host_wmask_i : '0;
    core_rvalid_o = !rst_i && mem_rvalid_i && resp_pend && !resp_sel;
    host_rvalid_o = !rst_i && mem_rvalid_i && resp_pend && resp_sel;
    core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
    next_state    = state == BOOT ? (reboot_i ? DRAIN : boot_done_i ? RUN : BOOT)
                  : state == RUN  ? (reboot_i ? DRAIN : RUN)
                  : (resp_pend ? DRAIN : BOOT);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= BOOT;
      core_halt_o <= 1'b1;
      wait_cnt    <= '0;
      resp_pend   <= 1'b0;
      resp_sel    <= 1'b0;
    end else begin
      state       <= next_state;
      core_halt_o <= next_state != RUN;
      resp_pend   <= mem_req_o && !mem_we_o;
      resp_sel    <= host_gnt_o;
      wait_cnt    <= (state != RUN || next_state != RUN || host_gnt_o || !host_req_i) ? '0
                   : starve ? wait_cnt : wait_cnt + 1'b1;
    end
  end
endmodule
